td4_prog_loader: RTL
====================

# td4_prog_loader

Writer end of the TD4 program-memory interface. It owns the 16×8 program RAM that the td4 core reads over MEM_ADDR/MEM_DATA, and it fills that RAM from a byte stream over a valid/ready handshake. The stream carries 16 program bytes followed by an optional checksum byte. While loading, the block asserts HOLD so the system stops the core from executing. It sits beside td4 in place of the fixed ROM.

## Interface
- ADDR_W, 4, program address width; depth is 2**ADDR_W = 16
- DATA_W, 8, instruction width
- CHECKSUM, 1, 1 = expect a trailing checksum byte; 0 = finish after the last program byte
- CLK  in  1  the only clock; all state changes on the rising edge
- RST  in  1  synchronous, active-high reset
- LD_START  in  1  single-cycle request to begin a load
- LD_VALID  in  1  LD_DATA holds a valid byte
- LD_DATA  in  DATA_W  program or checksum byte
- LD_READY  out  1  block accepts a byte this cycle
- MEM_ADDR  in  ADDR_W  read address from td4
- MEM_DATA  out  DATA_W  instruction at MEM_ADDR, combinational read
- HOLD  out  1  program memory invalid; the core must not execute
- DONE  out  1  last load completed with a good checksum
- ERR  out  1  last load failed its checksum

## Operation
- Handshake: a byte transfers when LD_VALID & LD_READY are both high at the rising CLK edge. Gaps in LD_VALID are allowed, and LD_DATA is ignored while LD_VALID is low.
- States are IDLE, LOAD, CHECK and FAULT.
  - IDLE: LD_READY=0 and HOLD=0. LD_START → LOAD.
  - Entering LOAD: the block clears idx and sum, clears DONE and ERR, and sets HOLD=1.
  - LOAD: LD_READY=1. Each transfer writes ram[idx] ← LD_DATA, sets sum ← sum + LD_DATA (mod 2**DATA_W), and increments idx. The transfer at idx = 15 goes to CHECK, or to IDLE with DONE=1 when CHECKSUM=0.
  - CHECK: LD_READY=1. On a transfer, LD_DATA == sum → IDLE with DONE=1. Any other value → FAULT with ERR=1.
  - FAULT: LD_READY=0, HOLD=1 and ERR=1. LD_START → LOAD. The RAM keeps the bad image.
- LD_START is ignored in LOAD and CHECK. LD_START in IDLE begins a reload, and DONE drops on the next cycle.
- RST from any state takes effect at the next edge:
  - state goes to IDLE;
  - all 16 RAM words become 0x00;
  - LD_READY, HOLD, DONE and ERR all become 0;
  - idx and sum are cleared.
  - A partial load is discarded.
- Reads: MEM_DATA = ram[MEM_ADDR] in every state, with no latency. A write takes effect at the edge, so a read of the same address in the same cycle returns the old word and the following cycle returns the new one.

## Timing
- Reset values: LD_READY=0, HOLD=0, DONE=0, ERR=0, and MEM_DATA=0x00 for every address.
- Outputs are Moore-decoded from registered state, with no combinational path from LD_VALID to LD_READY.
- LD_START is sampled at edge N. HOLD and LD_READY are high from cycle N+1.
- Back-to-back load with CHECKSUM=1: 17 transfers in cycles N+1…N+17. DONE=1 and HOLD=0 from cycle N+18.
- With CHECKSUM=0: 16 transfers. DONE=1 from cycle N+17.
- DONE and ERR are sticky until the next LD_START or RST. They are never both 1.

## Structure
- Shared package td4_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the program depth constant;
  - the loader state enumeration (IDLE, LOAD, CHECK, FAULT).
- Sub-module td4_prog_ram: 16×DATA_W storage with synchronous write (we, waddr, wdata), synchronous clear-all on RST, and an asynchronous read port. The loader FSM, index counter and checksum accumulator stay in td4_prog_loader.

## Test plan
- Reset: assert RST for 2 cycles, then sweep MEM_ADDR 0..15. Required: MEM_DATA=0x00 everywhere and all outputs 0.
- Good back-to-back load: LD_START, then bytes 0x00..0x0F, then checksum 0x78.
  - DONE=1 and HOLD=0 at cycle N+18, ERR=0.
  - MEM_ADDR=5 → 0x05 and MEM_ADDR=15 → 0x0F.
- Throttled load: the same stream with LD_VALID high every other cycle. Required: same final RAM image and DONE; the final transfer lands 33 cycles after LD_START.
- Bad checksum: send checksum 0x77.
  - ERR=1, DONE=0, HOLD stays 1.
  - A subsequent LD_START plus a good stream clears ERR and sets DONE.
- Reset mid-load: RST after the 7th transfer. Required: next cycle IDLE, HOLD=0, LD_READY=0, and all RAM words 0x00.
- Ignored restart and read-during-write: pulse LD_START during LOAD.
  - Required: idx is not reset.
  - Hold MEM_ADDR=3 while byte 0xA5 is written at idx=3. MEM_DATA shows the old value in the transfer cycle and 0xA5 in the next.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared TD4 definitions: bus widths, program depth and the loader state encoding.
package td4_pkg;

    localparam int TD4_ADDR_W     = 4;
    localparam int TD4_DATA_W     = 8;
    localparam int TD4_PROG_DEPTH = 2 ** TD4_ADDR_W;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        FAULT = 2'd3
    } ld_state_e;

endpackage

// File: rtl/td4_prog_loader_if.sv
// Program-load stream plus the td4 program-memory read port, bundled as one bus.
interface td4_prog_loader_if
    import td4_pkg::*;
#(
    parameter int ADDR_W = TD4_ADDR_W,
    parameter int DATA_W = TD4_DATA_W
);

    logic              LD_START;
    logic              LD_VALID;
    logic [DATA_W-1:0] LD_DATA;
    logic              LD_READY;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_DATA;
    logic              HOLD;
    logic              DONE;
    logic              ERR;

    // System side: issues the stream and the core's read address.
    modport master (
        output LD_START, LD_VALID, LD_DATA, MEM_ADDR,
        input  LD_READY, MEM_DATA, HOLD, DONE, ERR
    );

    // Loader side.
    modport slave (
        input  LD_START, LD_VALID, LD_DATA, MEM_ADDR,
        output LD_READY, MEM_DATA, HOLD, DONE, ERR
    );

endinterface

// File: rtl/td4_prog_ram.sv
// 2**ADDR_W x DATA_W program store: synchronous write, clear-all on RST, asynchronous read.
module td4_prog_ram
    import td4_pkg::*;
#(
    parameter int ADDR_W = TD4_ADDR_W,
    parameter int DATA_W = TD4_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; reset wipes every word so a partial image never survives.
    // NOTE: resetting every word forces this into plain flops instead of an
    // inferred RAM block; that is intended, the clear-all is functional here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read is combinational: a same-cycle write is seen only after the edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// TD4 program loader: fills the program RAM from a valid/ready byte stream,
// optionally verifies a trailing mod-2**DATA_W checksum, and holds the core meanwhile.
module td4_prog_loader
    import td4_pkg::*;
#(
    parameter int ADDR_W   = TD4_ADDR_W,
    parameter int DATA_W   = TD4_DATA_W,
    parameter bit CHECKSUM = 1'b1
) (
    input logic               CLK,
    input logic               RST,
    td4_prog_loader_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    ld_state_e         state_q;
    ld_state_e         state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] sum_q;
    logic              done_q;

    logic              ld_ready;
    logic              hold;
    logic              err;
    logic              xfer;
    logic              start_load;
    logic              finish_ok;
    logic              ram_we;

    // A byte moves only when the source offers it and the loader is accepting.
    assign xfer = bus.LD_VALID & ld_ready;

    // A new load may begin from IDLE or FAULT; LOAD/CHECK ignore LD_START.
    assign start_load = bus.LD_START & ((state_q == IDLE) | (state_q == FAULT));

    // Any return to IDLE other than via reset is a successful completion.
    assign finish_ok = ((state_q == LOAD) | (state_q == CHECK)) & (state_d == IDLE);

    // Only program bytes go to RAM; the checksum byte is compared, not stored.
    assign ram_we = xfer & (state_q == LOAD);

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    // NOTE: state_d takes a default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.LD_START) state_d = LOAD;
            end
            LOAD: begin
                if (xfer && (idx_q == LAST_IDX)) begin
                    state_d = CHECKSUM ? CHECK : IDLE;
                end
            end
            CHECK: begin
                if (xfer) state_d = (bus.LD_DATA == sum_q) ? IDLE : FAULT;
            end
            FAULT: begin
                if (bus.LD_START) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        ld_ready = 1'b0;
        hold     = 1'b0;
        err      = 1'b0;
        case (state_q)
            IDLE: begin
                ld_ready = 1'b0;
            end
            LOAD, CHECK: begin
                ld_ready = 1'b1;
                hold     = 1'b1;
            end
            FAULT: begin
                hold = 1'b1;
                err  = 1'b1;
            end
            default: begin
                ld_ready = 1'b0;
            end
        endcase
    end

    // Index counter, checksum accumulator and the sticky DONE flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q  <= '0;
            sum_q  <= '0;
            done_q <= 1'b0;
        end else begin
            if (start_load) begin
                idx_q  <= '0;
                sum_q  <= '0;
                done_q <= 1'b0;
            end else if (ram_we) begin
                idx_q <= idx_q + ADDR_W'(1);
                sum_q <= sum_q + bus.LD_DATA;
            end
            if (finish_ok) begin
                done_q <= 1'b1;
            end
        end
    end

    td4_prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .CLK   (CLK),
        .RST   (RST),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (bus.LD_DATA),
        .raddr (bus.MEM_ADDR),
        .rdata (bus.MEM_DATA)
    );

    assign bus.LD_READY = ld_ready;
    assign bus.HOLD     = hold;
    assign bus.ERR      = err;
    assign bus.DONE     = done_q;

endmodule
